// File: rtl/dsm_pkg.sv
// Shared types and default widths for the DSM frequency-sweep controller.
package dsm_pkg;

  localparam int unsigned DSM_ACC_FRAC_WIDTH = 24;
  localparam int unsigned DSM_ACC_INT_WIDTH  = 8;
  localparam int unsigned DSM_STEP_W         = DSM_ACC_FRAC_WIDTH + DSM_ACC_INT_WIDTH;
  localparam int unsigned DSM_DWELL_WIDTH    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_STEP  = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/dsm_dwell_timer.sv
// Dwell counter: loads a hold length minus one, counts down while running,
// and flags expiry during the final cycle of the hold.
module dsm_dwell_timer #(
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   run,
  input  logic [DWELL_WIDTH-1:0] load_val,
  output logic                   expire
);

  logic [DWELL_WIDTH-1:0] count_q;

  assign expire = run && (count_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (run && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/dsm_sweep_ctrl.sv
// Frequency-sweep controller: steps the DSM core NCO phase step from a start
// value to a stop value, holding each value for a programmable dwell.
module dsm_sweep_ctrl
  import dsm_pkg::*;
#(
  parameter  int unsigned ACC_FRAC_WIDTH = DSM_ACC_FRAC_WIDTH,
  parameter  int unsigned ACC_INT_WIDTH  = DSM_ACC_INT_WIDTH,
  parameter  int unsigned DWELL_WIDTH    = DSM_DWELL_WIDTH,
  localparam int unsigned STEP_W         = ACC_FRAC_WIDTH + ACC_INT_WIDTH
) (
  input  logic                   aclk,
  input  logic                   arst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   continuous,
  input  logic [STEP_W-1:0]      step_start,
  input  logic [STEP_W-1:0]      step_stop,
  input  logic [STEP_W-1:0]      step_inc,
  input  logic [DWELL_WIDTH-1:0] dwell_cycles,
  output logic [STEP_W-1:0]      nco_step,
  output logic                   nco_step_enable,
  output logic                   busy,
  output logic                   done
);

  sweep_state_t state_q, state_d;

  logic [STEP_W-1:0]      nco_q, nco_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   last_q, last_d;

  logic [STEP_W-1:0]      cfg_start_q, cfg_start_d;
  logic [STEP_W-1:0]      cfg_stop_q, cfg_stop_d;
  logic [STEP_W-1:0]      cfg_inc_q, cfg_inc_d;
  logic [DWELL_WIDTH-1:0] cfg_dwell_q, cfg_dwell_d;
  logic                   cfg_cont_q, cfg_cont_d;

  logic                   tmr_load;
  logic                   tmr_run;
  logic [DWELL_WIDTH-1:0] tmr_load_val;
  logic                   tmr_expire;
  logic [STEP_W:0]        sum;

  dsm_dwell_timer #(
    .DWELL_WIDTH(DWELL_WIDTH)
  ) u_dwell_timer (
    .clk      (aclk),
    .rst      (arst),
    .load     (tmr_load),
    .run      (tmr_run),
    .load_val (tmr_load_val),
    .expire   (tmr_expire)
  );

  assign sum = {1'b0, nco_q} + {1'b0, cfg_inc_q};

  // STEP marks the first cycle a newly stepped value is presented; it dwells
  // exactly like DWELL so consecutive values follow with no dead cycle.
  always_comb begin
    state_d      = state_q;
    nco_d        = nco_q;
    en_d         = en_q;
    done_d       = 1'b0;
    last_d       = last_q;
    cfg_start_d  = cfg_start_q;
    cfg_stop_d   = cfg_stop_q;
    cfg_inc_d    = cfg_inc_q;
    cfg_dwell_d  = cfg_dwell_q;
    cfg_cont_d   = cfg_cont_q;
    tmr_load     = 1'b0;
    tmr_run      = 1'b0;
    tmr_load_val = cfg_dwell_q;

    unique case (state_q)
      ST_IDLE: begin
        en_d = 1'b0;
        if (start && !stop) begin
          cfg_start_d  = step_start;
          cfg_stop_d   = step_stop;
          cfg_inc_d    = step_inc;
          cfg_dwell_d  = dwell_cycles;
          cfg_cont_d   = continuous;
          nco_d        = step_start;
          en_d         = 1'b1;
          last_d       = (step_inc == '0) || (step_start >= step_stop);
          tmr_load     = 1'b1;
          tmr_load_val = dwell_cycles;
          state_d      = ST_DWELL;
        end
      end

      ST_DWELL, ST_STEP: begin
        tmr_run = 1'b1;
        if (stop) begin
          en_d    = 1'b0;
          state_d = ST_IDLE;
        end else if (tmr_expire) begin
          if (last_q) begin
            if (cfg_cont_q) begin
              nco_d    = cfg_start_q;
              last_d   = (cfg_inc_q == '0) || (cfg_start_q >= cfg_stop_q);
              tmr_load = 1'b1;
              state_d  = ST_DWELL;
            end else begin
              en_d    = 1'b0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            // Overflow of the step width counts as reaching the stop value.
            if (sum[STEP_W] || (sum[STEP_W-1:0] >= cfg_stop_q)) begin
              nco_d  = cfg_stop_q;
              last_d = 1'b1;
            end else begin
              nco_d  = sum[STEP_W-1:0];
              last_d = 1'b0;
            end
            tmr_load = 1'b1;
            state_d  = ST_STEP;
          end
        end else begin
          state_d = ST_DWELL;
        end
      end

      ST_DONE: begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q     <= ST_IDLE;
      nco_q       <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      last_q      <= 1'b0;
      cfg_start_q <= '0;
      cfg_stop_q  <= '0;
      cfg_inc_q   <= '0;
      cfg_dwell_q <= '0;
      cfg_cont_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      nco_q       <= nco_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      last_q      <= last_d;
      cfg_start_q <= cfg_start_d;
      cfg_stop_q  <= cfg_stop_d;
      cfg_inc_q   <= cfg_inc_d;
      cfg_dwell_q <= cfg_dwell_d;
      cfg_cont_q  <= cfg_cont_d;
    end
  end

  assign nco_step        = nco_q;
  assign nco_step_enable = en_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_dsm_sweep_ctrl.sv
// Directed self-checking bench for dsm_sweep_ctrl with hand-computed expectations.
module tb_dsm_sweep_ctrl;

  localparam int unsigned STEP_W  = 32;
  localparam int unsigned DWELL_W = 16;

  logic              aclk = 1'b0;
  logic              arst;
  logic              start, stop, continuous;
  logic [STEP_W-1:0] step_start, step_stop, step_inc;
  logic [DWELL_W-1:0] dwell_cycles;
  logic [STEP_W-1:0] nco_step;
  logic              nco_step_enable, busy, done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 aclk = ~aclk;

  dsm_sweep_ctrl #(
    .ACC_FRAC_WIDTH(24),
    .ACC_INT_WIDTH (8),
    .DWELL_WIDTH   (DWELL_W)
  ) dut (
    .aclk            (aclk),
    .arst            (arst),
    .start           (start),
    .stop            (stop),
    .continuous      (continuous),
    .step_start      (step_start),
    .step_stop       (step_stop),
    .step_inc        (step_inc),
    .dwell_cycles    (dwell_cycles),
    .nco_step        (nco_step),
    .nco_step_enable (nco_step_enable),
    .busy            (busy),
    .done            (done)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_nco, input logic e_en,
                         input logic e_busy, input logic e_done);
    chk({tag, ".nco"},  {32'd0, nco_step},       {32'd0, e_nco});
    chk({tag, ".en"},   {63'd0, nco_step_enable}, {63'd0, e_en});
    chk({tag, ".busy"}, {63'd0, busy},            {63'd0, e_busy});
    chk({tag, ".done"}, {63'd0, done},            {63'd0, e_done});
  endtask

  task automatic set_cfg(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] inc,
                         input logic [15:0] dw, input logic cont);
    step_start   = s0;
    step_stop    = s1;
    step_inc     = inc;
    dwell_cycles = dw;
    continuous   = cont;
  endtask

  initial begin
    logic [31:0] cont_seq [7];
    cont_seq = '{32'h10, 32'h20, 32'h30, 32'h10, 32'h20, 32'h30, 32'h10};

    arst  = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    set_cfg(32'h0, 32'h0, 32'h0, 16'd0, 1'b0);
    tick();
    chk_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    arst = 1'b0;
    tick();
    chk_out("idle", 32'h0, 1'b0, 1'b0, 1'b0);

    // Basic sweep: 0x100..0x400, 3 cycles each
    set_cfg(32'h100, 32'h400, 32'h100, 16'd2, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    set_cfg(32'h0, 32'h0, 32'h0, 16'd0, 1'b0);
    for (int v = 1; v <= 4; v++) begin
      for (int k = 0; k < 3; k++) begin
        chk_out($sformatf("sweep_v%0d_c%0d", v, k), 32'(v) * 32'h100, 1'b1, 1'b1, 1'b0);
        tick();
      end
    end
    chk_out("sweep_done", 32'h400, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("sweep_idle", 32'h400, 1'b0, 1'b0, 1'b0);

    // Carry out of the step width clamps to stop
    set_cfg(32'hF000_0000, 32'hFFFF_FFFF, 32'h2000_0000, 16'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("carry_v0", 32'hF000_0000, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("carry_v1", 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("carry_done", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("carry_idle", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    // Continuous sweep, then abort
    set_cfg(32'h10, 32'h30, 32'h10, 16'd0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk_out($sformatf("cont_%0d", i), cont_seq[i], 1'b1, 1'b1, 1'b0);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("cont_stop", 32'h20, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("cont_after", 32'h20, 1'b0, 1'b0, 1'b0);

    // Zero increment, restart attempts while busy and in DONE
    set_cfg(32'h500, 32'h900, 32'h0, 16'd4, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("inc0_c0", 32'h500, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("inc0_c1", 32'h500, 1'b1, 1'b1, 1'b0);
    set_cfg(32'h700, 32'h900, 32'h100, 16'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("inc0_c2", 32'h500, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("inc0_c3", 32'h500, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("inc0_c4", 32'h500, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("inc0_done", 32'h500, 1'b0, 1'b1, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("done_start_ign", 32'h500, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("done_start_ign2", 32'h500, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-dwell
    set_cfg(32'h100, 32'h400, 32'h100, 16'd2, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("pre_rst", 32'h100, 1'b1, 1'b1, 1'b0);
    #2;
    arst = 1'b1;
    #1;
    chk_out("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    arst = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk_out("start_stop", 32'h0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("restart_c0", 32'h100, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("restart_c1", 32'h100, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("restart_c2", 32'h100, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("restart_v1", 32'h200, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("restart_stop", 32'h200, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsm_sweep_ctrl.md
DSM_SWEEP_CTRL -- requirements
Module: dsm_sweep_ctrl

Interface
REQ-001 Parameter ACC_FRAC_WIDTH, default 24: fractional bits of the NCO phase step.
REQ-002 Parameter ACC_INT_WIDTH, default 8: integer bits of the NCO phase step; STEP_W = ACC_FRAC_WIDTH+ACC_INT_WIDTH.
REQ-003 Parameter DWELL_WIDTH, default 16: width of the dwell counter.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 aclk  input  1  sole clock, rising edge.
REQ-006 arst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  single-cycle sweep start request.
REQ-008 stop  input  1  single-cycle abort request.
REQ-009 continuous  input  1  repeat sweep until stop; sampled with start.
REQ-010 step_start  input  STEP_W  first phase step, unsigned.
REQ-011 step_stop  input  STEP_W  final phase step, unsigned.
REQ-012 step_inc  input  STEP_W  increment per dwell, unsigned.
REQ-013 dwell_cycles  input  DWELL_WIDTH  hold length minus one per step.
REQ-014 nco_step  output  STEP_W  phase step to the DSM core NCO input.
REQ-015 nco_step_enable  output  1  valid qualifier for nco_step.
REQ-016 busy  output  1  high in any non-IDLE state.
REQ-017 done  output  1  one-cycle pulse on normal (non-aborted) completion.

Function
REQ-018 States SHALL be IDLE, DWELL, STEP, DONE; registered outputs only.
REQ-019 IDLE + start (stop low): capture step_start/stop/inc, dwell_cycles, continuous; next cycle nco_step=step_start, nco_step_enable=1, state DWELL (latency 1 cycle).
REQ-020 Config inputs SHALL be ignored outside the start capture cycle.
REQ-021 DWELL: each nco_step value SHALL be held exactly dwell_cycles+1 cycles (dwell_cycles=0 -> 1 cycle), then STEP.
REQ-022 STEP: next = current + step_inc computed in STEP_W+1 bits; if carry or next >= step_stop, nco_step=step_stop and it is the final dwell; else nco_step=next; return to DWELL in the same cycle (no dead cycle between values).
REQ-023 Degenerate: step_inc==0 or step_start>=step_stop -> only step_start is output for one dwell, then completion.
REQ-024 Completion (final dwell expires): continuous=0 -> DONE for one cycle with done=1, then IDLE; continuous=1 -> nco_step=step_start immediately, no done pulse.
REQ-025 In IDLE/DONE nco_step_enable SHALL be 0 and nco_step SHALL retain its last value.
REQ-026 stop in any non-IDLE state: next cycle IDLE, nco_step_enable=0, busy=0, no done pulse.
REQ-027 start while busy SHALL be ignored; start and stop in the same IDLE cycle: stop wins, remain IDLE.
REQ-028 start in the DONE cycle SHALL be ignored.

Reset
REQ-029 arst high SHALL immediately force state=IDLE, nco_step=0, nco_step_enable=0, busy=0, done=0, dwell counter=0, captured config=0.
REQ-030 Reset mid-sweep SHALL abort without done; first start after release behaves as from power-up.

Structure
REQ-031 Shared package dsm_pkg SHALL hold the state enum typedef and the STEP_W default-derived localparam.
REQ-032 One sub-module dsm_dwell_timer (load, count-down, expire pulse, DWELL_WIDTH wide) SHALL implement the dwell counter.
REQ-033 Output nco_step/nco_step_enable SHALL connect directly to the DSM core nco_step/nco_step_enable inputs with no glue logic.

Verification
REQ-034 start=1, start=0x100, stop=0x400, inc=0x100, dwell=2 -> nco_step 0x100,0x200,0x300,0x400 each 3 cycles, done pulse 1 cycle after last, enable low afterwards.
REQ-035 start=0xF000_0000, stop=0xFFFF_FFFF, inc=0x2000_0000 -> carry detected, second value 0xFFFF_FFFF, then done.
REQ-036 continuous=1, start=0x10, stop=0x30, inc=0x10, dwell=0 -> repeating 0x10,0x20,0x30,0x10,... no done; stop -> enable 0 next cycle, busy 0, no done.
REQ-037 inc=0, start=0x500, dwell=4 -> 0x500 for 5 cycles then done; second start during busy ignored (no restart of sequence).
REQ-038 arst asserted mid-DWELL -> outputs zero asynchronously; start and stop same cycle in IDLE -> busy stays 0.
